// File: rtl/chipset_bus_pkg.sv
// Shared types and idle levels for the 8088 minimum-mode bus signal set.
package chipset_bus_pkg;

  typedef enum logic [2:0] {
    CMD_MEMR = 3'd0,
    CMD_MEMW = 3'd1,
    CMD_IOR  = 3'd2,
    CMD_IOW  = 3'd3,
    CMD_INTA = 3'd4
  } bus_cmd_t;

  typedef enum logic [2:0] {
    TI,
    T1,
    T2,
    T3,
    TW,
    T4,
    TGAP,
    THLD
  } bus_state_t;

  localparam logic [19:0] IDLE_ADDRESS  = 20'h00000;
  localparam logic [7:0]  IDLE_DATA_OUT = 8'hFF;
  localparam logic        IDLE_ALE      = 1'b0;
  localparam logic        IDLE_STROBE_N = 1'b1;
  localparam logic        IDLE_IO_OR_M  = 1'b0;
  localparam logic        IDLE_DT_OR_R  = 1'b0;

  function automatic logic cmd_is_read(input bus_cmd_t c);
    return (c == CMD_MEMR) || (c == CMD_IOR);
  endfunction

  function automatic logic cmd_is_write(input bus_cmd_t c);
    return (c == CMD_MEMW) || (c == CMD_IOW);
  endfunction

  function automatic logic cmd_is_io(input bus_cmd_t c);
    return (c == CMD_IOR) || (c == CMD_IOW) || (c == CMD_INTA);
  endfunction

endpackage

// File: rtl/bus_cycle_initiator.sv
// 8088 minimum-mode bus master: turns single-transfer requests into T1..T4
// bus cycles with RDY-driven wait states, paired INTA cycles and HOLD/HLDA.
module bus_cycle_initiator
  import chipset_bus_pkg::*;
#(
  parameter int unsigned INTA_GAP     = 2,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_clock_posedge,
  input  logic        cpu_clock_negedge,
  input  logic        req_valid,
  output logic        req_ready,
  input  bus_cmd_t    req_cmd,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] ADDRESS,
  output logic [7:0]  DATA_OUT,
  input  logic [7:0]  DATA_IN,
  output logic        ALE,
  output logic        RD_N,
  output logic        WR_N,
  output logic        IO_OR_M,
  output logic        DT_OR_R,
  output logic        DEN_N,
  output logic        INTA_N,
  input  logic        RDY,
  input  logic        HOLD,
  output logic        HLDA
);

  localparam int CNT_W = 16;

  bus_state_t       state;
  bus_state_t       state_nxt;
  bus_cmd_t         cmd_q;
  bus_cmd_t         cyc_cmd;
  logic [7:0]       wdata_q;
  logic             inta_second;
  logic             rdy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] tw_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             adv;
  logic             accept;
  logic             first_inta;
  logic             force_t4;
  logic             gap_done;
  logic             in_wait;
  logic             leave_wait;
  logic             cyc_done;
  logic             strobe_nxt;

  assign adv        = cpu_clock_posedge;
  assign first_inta = (cmd_q == CMD_INTA) && !inta_second;
  // The gap between the two INTA pulses belongs to one transaction, so no
  // new request or hold may slip in at the first INTA's T4.
  assign req_ready  = ((state == TI) || ((state == T4) && !first_inta)) && !HOLD && !HLDA;
  assign accept     = adv && req_valid && req_ready;
  assign cyc_cmd    = accept ? req_cmd : cmd_q;
  assign force_t4   = (WAIT_TIMEOUT != 0) && (tw_cnt >= CNT_W'(WAIT_TIMEOUT));
  assign gap_done   = (gap_cnt + 1'b1) >= CNT_W'(INTA_GAP);
  assign in_wait    = (state == T3) || (state == TW);
  assign leave_wait = adv && in_wait && (state_nxt == T4);
  assign cyc_done   = adv && (state == T4) && !first_inta;
  assign strobe_nxt = (state_nxt == T2) || (state_nxt == T3) || (state_nxt == TW);

  // Bus state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= TI;
    else        state <= state_nxt;
  end

  // Next bus state, evaluated only on CPU-clock rising phases
  always_comb begin
    state_nxt = state;
    if (adv) begin
      case (state)
        TI: begin
          if (HOLD)        state_nxt = THLD;
          else if (accept) state_nxt = T1;
        end
        T1: state_nxt = T2;
        T2: state_nxt = T3;
        T3, TW: begin
          if (rdy_q || force_t4) state_nxt = T4;
          else                   state_nxt = TW;
        end
        T4: begin
          if (first_inta)  state_nxt = (INTA_GAP == 0) ? T1 : TGAP;
          else if (HOLD)   state_nxt = THLD;
          else if (accept) state_nxt = T1;
          else             state_nxt = TI;
        end
        TGAP: if (gap_done) state_nxt = T1;
        THLD: if (!HOLD)    state_nxt = TI;
        default: state_nxt = TI;
      endcase
    end
  end

  // Transfer bookkeeping: INTA pairing, wait-state count, TGAP spacing, timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inta_second <= 1'b0;
      tw_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_q   <= 1'b0;
    end else if (adv) begin
      if (accept)                        inta_second <= 1'b0;
      else if ((state == T4) && first_inta) inta_second <= 1'b1;

      if (state_nxt == T1)                      tw_cnt <= '0;
      else if ((state_nxt == TW) && (tw_cnt != '1)) tw_cnt <= tw_cnt + 1'b1;

      if (state_nxt == T1)  timeout_q <= 1'b0;
      else if (leave_wait)  timeout_q <= force_t4 && !rdy_q;

      if (state == TGAP) gap_cnt <= gap_cnt + 1'b1;
      else               gap_cnt <= '0;
    end
  end

  // RDY sampled on the falling phase of T3/TW; consumed at the next rising phase
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                             rdy_q <= 1'b0;
    else if (adv)                           rdy_q <= 1'b0;
    else if (cpu_clock_negedge && in_wait)  rdy_q <= RDY;
  end

  // Request payload captured on accept
  always_ff @(posedge clock) begin
    if (accept) begin
      cmd_q   <= req_cmd;
      wdata_q <= req_wdata;
    end
  end

  // Bus pins: ALE pulse, strobes, direction and hold acknowledge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ADDRESS  <= IDLE_ADDRESS;
      DATA_OUT <= IDLE_DATA_OUT;
      ALE      <= IDLE_ALE;
      RD_N     <= IDLE_STROBE_N;
      WR_N     <= IDLE_STROBE_N;
      DEN_N    <= IDLE_STROBE_N;
      INTA_N   <= IDLE_STROBE_N;
      IO_OR_M  <= IDLE_IO_OR_M;
      DT_OR_R  <= IDLE_DT_OR_R;
      HLDA     <= 1'b0;
    end else if (adv) begin
      ALE    <= (state_nxt == T1);
      RD_N   <= !(strobe_nxt && cmd_is_read(cmd_q));
      WR_N   <= !(strobe_nxt && cmd_is_write(cmd_q));
      INTA_N <= !(strobe_nxt && (cmd_q == CMD_INTA));
      DEN_N  <= !strobe_nxt;
      HLDA   <= (state_nxt == THLD);
      if (accept) ADDRESS <= req_address;
      if ((state_nxt == T2) && cmd_is_write(cmd_q)) DATA_OUT <= wdata_q;
      if (state_nxt == T1) begin
        IO_OR_M <= cmd_is_io(cyc_cmd);
        DT_OR_R <= cmd_is_write(cyc_cmd);
      end else if ((state_nxt == TI) || (state_nxt == THLD)) begin
        IO_OR_M <= IDLE_IO_OR_M;
        DT_OR_R <= IDLE_DT_OR_R;
      end
    end else if (cpu_clock_negedge && (state == T1)) begin
      ALE <= IDLE_ALE;
    end
  end

  // Completion response: read data or vector, one-clock valid pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= cyc_done;
      rsp_timeout <= cyc_done && timeout_q;
      if (leave_wait && !cmd_is_write(cmd_q)) rsp_rdata <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Bench for bus_cycle_initiator: directed scenarios plus random transfers
// against a cycle-count model of the 8088 bus timing.
module tb_bus_cycle_initiator;
  import chipset_bus_pkg::*;

  localparam int GAP = 2;
  localparam int TO  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_clock_posedge;
  logic        cpu_clock_negedge;
  logic        req_valid;
  logic        req_ready;
  bus_cmd_t    req_cmd;
  logic [19:0] req_address;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] ADDRESS;
  logic [7:0]  DATA_OUT;
  logic [7:0]  DATA_IN;
  logic        ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N, INTA_N;
  logic        RDY;
  logic        HOLD;
  logic        HLDA;

  bus_cycle_initiator #(.INTA_GAP(GAP), .WAIT_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
    .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M), .DT_OR_R(DT_OR_R),
    .DEN_N(DEN_N), .INTA_N(INTA_N), .RDY(RDY), .HOLD(HOLD), .HLDA(HLDA)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // snapshot of the pins taken 1 ns after the rising-phase edge of a CPU clock
  logic s_ale, s_ale_neg, s_rd, s_wr, s_inta, s_den, s_io, s_dt, s_hlda, s_ready_pre;
  logic [7:0]  s_dout;
  logic [19:0] s_addr;
  int          rsp_hits;
  logic [7:0]  rsp_data_seen;
  logic        rsp_to_seen;
  logic [7:0]  model_rdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_rsp();
    if (rsp_valid === 1'b1) begin
      rsp_hits++;
      rsp_data_seen = rsp_rdata;
      rsp_to_seen   = rsp_timeout;
    end
  endtask

  // One CPU clock = 4 system clocks: rising phase, idle, falling phase, idle
  task automatic cpu_tick();
    s_ready_pre = req_ready;
    cpu_clock_posedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_posedge = 1'b0;
    s_ale = ALE; s_rd = RD_N; s_wr = WR_N; s_inta = INTA_N; s_den = DEN_N;
    s_io = IO_OR_M; s_dt = DT_OR_R; s_hlda = HLDA; s_dout = DATA_OUT; s_addr = ADDRESS;
    note_rsp();
    @(posedge clock); #1; note_rsp();
    cpu_clock_negedge = 1'b1;
    @(posedge clock); #1;
    cpu_clock_negedge = 1'b0;
    s_ale_neg = ALE;
    note_rsp();
    @(posedge clock); #1; note_rsp();
  endtask

  // Runs one transfer from TI. w1/w2 = RDY-low negedges in the (first/second)
  // bus cycle; hold_tick >= 0 raises HOLD before that CPU clock.
  task automatic do_txn(input bus_cmd_t cmd, input logic [19:0] addr, input logic [7:0] wd,
                        input int w1, input int w2, input logic [7:0] din, input int hold_tick);
    bit rd, wr, io, inta, exp_to, act, gap;
    int we1, we2, s2, last, base, w, r;
    rd   = (cmd == CMD_MEMR) || (cmd == CMD_IOR);
    wr   = (cmd == CMD_MEMW) || (cmd == CMD_IOW);
    inta = (cmd == CMD_INTA);
    io   = (cmd == CMD_IOR) || (cmd == CMD_IOW) || inta;
    we1  = (w1 > TO) ? TO : w1;
    we2  = (w2 > TO) ? TO : w2;
    if (inta) begin
      s2     = 4 + we1 + GAP;
      last   = s2 + 4 + we2;
      exp_to = (w2 > TO);
    end else begin
      s2     = 1 << 20;
      last   = 4 + we1;
      exp_to = (w1 > TO);
    end
    req_cmd = cmd; req_address = addr; req_wdata = wd; req_valid = 1'b1;
    rsp_hits = 0;
    for (int k = 0; k <= last; k++) begin
      if (k >= s2) begin base = s2; w = w2; end
      else         begin base = 0;  w = w1; end
      r       = k - base;
      gap     = inta && (k >= 4 + we1) && (k < s2);
      act     = (r >= 1) && (r <= 2 + ((k >= s2) ? we2 : we1)) && !gap;
      RDY     = (r - 2 >= w);
      DATA_IN = (inta && k < s2) ? ~din : din;
      if (hold_tick >= 0 && k == hold_tick) HOLD = 1'b1;
      cpu_tick();
      if (k == 0) begin
        req_valid = 1'b0;
        chk1("accept_ready", s_ready_pre, 1'b1);
      end
      if (k < last) begin
        chk1("ale_rise", s_ale, (r == 0) && !gap);
        chk1("ale_fall", s_ale_neg, 1'b0);
        chk1("rd_n", s_rd, !(act && rd));
        chk1("wr_n", s_wr, !(act && wr));
        chk1("inta_n", s_inta, !(act && inta));
        chk1("den_n", s_den, !act);
        chk1("hlda_busy", s_hlda, 1'b0);
        chkv("rsp_early", 32'(rsp_hits), 32'd0);
        if (!gap) begin
          chk1("io_or_m", s_io, io);
          chk1("dt_or_r", s_dt, wr);
        end
        if (act && wr) chkv("data_out", 32'(s_dout), 32'(wd));
        if (!inta)     chkv("address", 32'(s_addr), 32'(addr));
      end else begin
        if (!wr) model_rdata = din;
        chkv("rsp_count", 32'(rsp_hits), 32'd1);
        chkv("rsp_rdata", 32'(rsp_data_seen), 32'(model_rdata));
        chk1("rsp_timeout", rsp_to_seen, exp_to);
        chk1("hlda_end", s_hlda, hold_tick >= 0);
        chk1("strobes_idle", s_rd & s_wr & s_inta & s_den, 1'b1);
      end
    end
  endtask

  initial begin
    reset = 1'b0; cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
    req_valid = 1'b0; req_cmd = CMD_MEMR; req_address = '0; req_wdata = '0;
    DATA_IN = '0; RDY = 1'b1; HOLD = 1'b0; model_rdata = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chkv("rst_address", 32'(ADDRESS), 32'h0);
    chkv("rst_data_out", 32'(DATA_OUT), 32'hFF);
    chk1("rst_ale", ALE, 1'b0);
    chk1("rst_rd_n", RD_N, 1'b1);
    chk1("rst_wr_n", WR_N, 1'b1);
    chk1("rst_den_n", DEN_N, 1'b1);
    chk1("rst_inta_n", INTA_N, 1'b1);
    chk1("rst_io_or_m", IO_OR_M, 1'b0);
    chk1("rst_dt_or_r", DT_OR_R, 1'b0);
    chk1("rst_hlda", HLDA, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chkv("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    reset = 1'b1;
    cpu_tick();
    chk1("idle_ready", req_ready, 1'b1);

    // basic read, write with waits, interrupt acknowledge pair
    do_txn(CMD_MEMR, 20'hF0000, 8'h00, 0, 0, 8'h5A, -1);
    do_txn(CMD_IOW,  20'h00021, 8'h13, 2, 0, 8'h00, -1);
    do_txn(CMD_INTA, 20'h00000, 8'h00, 0, 0, 8'h08, -1);

    // HOLD raised during the T3 of a write; a queued read waits for release
    do_txn(CMD_MEMW, 20'h12345, 8'hA7, 0, 0, 8'h00, 3);
    req_cmd = CMD_MEMR; req_address = 20'hF0001; req_valid = 1'b1;
    repeat (3) begin
      cpu_tick();
      chk1("hold_hlda", s_hlda, 1'b1);
      chk1("hold_ready", s_ready_pre, 1'b0);
      chk1("hold_ale", s_ale, 1'b0);
      chk1("hold_strobes", s_rd & s_wr & s_den & s_inta, 1'b1);
      chk1("hold_io_or_m", s_io, 1'b0);
    end
    HOLD = 1'b0;
    cpu_tick();
    chk1("release_hlda", s_hlda, 1'b0);
    chk1("release_no_t1", s_ale, 1'b0);
    do_txn(CMD_MEMR, 20'hF0001, 8'h00, 0, 0, 8'h3C, -1);

    // wait-state timeout, and RDY arriving exactly at the limit
    do_txn(CMD_MEMR, 20'h0BEEF, 8'h00, 9, 0, 8'hC3, -1);
    do_txn(CMD_IOR,  20'h00060, 8'h00, TO, 0, 8'h77, -1);
    do_txn(CMD_INTA, 20'h00000, 8'h00, 1, 9, 8'h21, -1);

    // random transfers
    for (int n = 0; n < 24; n++) begin
      do_txn(bus_cmd_t'(3'($urandom_range(0, 4))), 20'($urandom), 8'($urandom),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 8'($urandom), -1);
    end

    // reset pulled in T2 of an I/O read
    req_cmd = CMD_IOR; req_address = 20'h003F8; req_valid = 1'b1; RDY = 1'b1; DATA_IN = 8'h99;
    rsp_hits = 0;
    cpu_tick();
    req_valid = 1'b0;
    cpu_tick();
    chk1("t2_rd_n", s_rd, 1'b0);
    chk1("t2_den_n", s_den, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk1("abort_rd_n", RD_N, 1'b1);
    chk1("abort_den_n", DEN_N, 1'b1);
    chk1("abort_io_or_m", IO_OR_M, 1'b0);
    chkv("abort_address", 32'(ADDRESS), 32'h0);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_rdata = 8'h00;
    repeat (4) cpu_tick();
    chkv("abort_no_rsp", 32'(rsp_hits), 32'd0);
    chk1("abort_strobes", s_rd & s_den, 1'b1);
    chk1("abort_ready", req_ready, 1'b1);
    do_txn(CMD_MEMR, 20'h00400, 8'h00, 1, 0, 8'h4E, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
